// File: rtl/reg_desloc_univ_if.sv
// reg_desloc_univ_if: bus for the universal register; master drives En/Mode/D/SinR/SinL, slave returns Q/SoutR/SoutL/Zero
interface reg_desloc_univ_if #(parameter int WIDTH = 8);
  logic             En;
  logic [2:0]       Mode;
  logic [WIDTH-1:0] D;
  logic             SinR;
  logic             SinL;
  logic [WIDTH-1:0] Q;
  logic             SoutR;
  logic             SoutL;
  logic             Zero;
  modport master (output En, Mode, D, SinR, SinL, input Q, SoutR, SoutL, Zero);
  modport slave (input En, Mode, D, SinR, SinL, output Q, SoutR, SoutL, Zero);
endinterface

// File: rtl/reg_desloc_univ.sv
// reg_desloc_univ: WIDTH-bit hold/shift/rotate/load/clear/invert register; ports Clk, Reset (sync, active-high), bus (En, Mode, D, SinR, SinL in; Q, SoutR, SoutL, Zero out)
module reg_desloc_univ #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0
) (
  input logic               Clk,
  input logic               Reset,
  reg_desloc_univ_if.slave  bus
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_r_q, sout_r_d, sout_l_q, sout_l_d;
  logic [2:0]       m;
  always_comb begin
    m        = bus.Mode;
    q_d      = !bus.En        ? q_q :
               m == 3'b001    ? {bus.SinR, q_q[WIDTH-1:1]} :
               m == 3'b010    ? {q_q[WIDTH-2:0], bus.SinL} :
               m == 3'b011    ? {q_q[0], q_q[WIDTH-1:1]} :
               m == 3'b100    ? {q_q[WIDTH-2:0], q_q[WIDTH-1]} :
               m == 3'b101    ? bus.D :
               m == 3'b110    ? '0 :
               m == 3'b111    ? ~q_q : q_q;
    sout_r_d = bus.En && (m == 3'b001 || m == 3'b011) ? q_q[0] : sout_r_q;
    sout_l_d = bus.En && (m == 3'b010 || m == 3'b100) ? q_q[WIDTH-1] : sout_l_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q      <= RESET_VALUE[WIDTH-1:0];
      sout_r_q <= 1'b0;
      sout_l_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      sout_r_q <= sout_r_d;
      sout_l_q <= sout_l_d;
    end
  end
  assign bus.Q     = q_q;
  assign bus.SoutR = sout_r_q;
  assign bus.SoutL = sout_l_q;
  assign bus.Zero  = (q_q == '0);
endmodule
